// File: rtl/laser_target_scheduler_if.sv
// Signal bundle between the camera top level and the laser target scheduler.
// The scheduler uses the slave modport.
interface laser_target_scheduler_if;
    logic        vsync_raw;
    logic        start;
    logic [16:0] x_red;
    logic [16:0] y_red;
    logic [16:0] x_green;
    logic [16:0] y_green;
    logic [31:0] x_target;
    logic [31:0] y_target;
    logic [7:0]  score_red;
    logic [7:0]  score_green;
    logic [7:0]  rounds_left;
    logic        round_active;
    logic        hit_red;
    logic        hit_green;
    logic [2:0]  state_dbg;

    modport master (
        output vsync_raw, start, x_red, y_red, x_green, y_green,
        input  x_target, y_target, score_red, score_green, rounds_left,
               round_active, hit_red, hit_green, state_dbg
    );

    modport slave (
        input  vsync_raw, start, x_red, y_red, x_green, y_green,
        output x_target, y_target, score_red, score_green, rounds_left,
               round_active, hit_red, hit_green, state_dbg
    );
endinterface

// File: rtl/laser_target_scheduler.sv
// Game-round controller: places pseudo-random targets, tests red/green laser
// centroids against them once per camera frame and keeps per-player scores.
module laser_target_scheduler #(
    parameter int unsigned H_RES         = 320,
    parameter int unsigned V_RES         = 240,
    parameter int unsigned HIT_RADIUS    = 16,
    parameter int unsigned HOLD_FRAMES   = 4,
    parameter int unsigned ROUND_FRAMES  = 300,
    parameter int unsigned NUM_ROUNDS    = 8,
    parameter int unsigned TARGET_MARGIN = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk25,
    input  logic                     reset,
    laser_target_scheduler_if.slave  lts
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned FRAME_W = $clog2(ROUND_FRAMES + 1);
    localparam logic signed [17:0] RAD = 18'(HIT_RADIUS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLACE = 3'd1,
        S_TRACK = 3'd2,
        S_SCORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic                vs_meta_q, vs_sync_q, vs_prev_q;
    logic                tick_q, eval_q;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [16:0]         xr_q, yr_q, xg_q, yg_q;
    logic [16:0]         tx_q, ty_q;
    logic [HOLD_W-1:0]   hold_r_q, hold_g_q, hold_r_d, hold_g_d;
    logic [FRAME_W-1:0]  frame_q;
    logic [7:0]          score_r_q, score_g_q, rounds_q, rounds_dec_d;
    logic                active_q, hit_r_q, hit_g_q;
    logic                in_r_d, in_g_d, win_r_d, win_g_d, accept_d;
    logic [8:0]          cand_x_d;
    logic [7:0]          cand_y_d;

    function automatic logic in_box(input logic [16:0] x, input logic [16:0] y,
                                    input logic [16:0] tx, input logic [16:0] ty);
        logic signed [17:0] dx, dy, ax, ay;
        dx = $signed({1'b0, x}) - $signed({1'b0, tx});
        dy = $signed({1'b0, y}) - $signed({1'b0, ty});
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        return (ax <= RAD) && (ay <= RAD) && !((x == '0) && (y == '0));
    endfunction

    always_comb begin
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        in_r_d       = in_box(xr_q, yr_q, tx_q, ty_q);
        in_g_d       = in_box(xg_q, yg_q, tx_q, ty_q);
        hold_r_d     = in_r_d ? hold_r_q + HOLD_W'(1) : '0;
        hold_g_d     = in_g_d ? hold_g_q + HOLD_W'(1) : '0;
        win_r_d      = (hold_r_d == HOLD_W'(HOLD_FRAMES));
        win_g_d      = (hold_g_d == HOLD_W'(HOLD_FRAMES));
        cand_x_d     = lfsr_q[8:0];
        cand_y_d     = lfsr_q[15:8];
        accept_d     = (32'(cand_x_d) < (H_RES - 2 * TARGET_MARGIN)) &&
                       (32'(cand_y_d) < (V_RES - 2 * TARGET_MARGIN));
        rounds_dec_d = (rounds_q == '0) ? '0 : rounds_q - 8'd1;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q   <= S_IDLE;
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
            eval_q    <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            xr_q      <= '0;
            yr_q      <= '0;
            xg_q      <= '0;
            yg_q      <= '0;
            tx_q      <= 17'(H_RES / 2);
            ty_q      <= 17'(V_RES / 2);
            hold_r_q  <= '0;
            hold_g_q  <= '0;
            frame_q   <= '0;
            score_r_q <= '0;
            score_g_q <= '0;
            rounds_q  <= '0;
            active_q  <= 1'b0;
            hit_r_q   <= 1'b0;
            hit_g_q   <= 1'b0;
        end else begin
            vs_meta_q <= lts.vsync_raw;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            tick_q    <= vs_sync_q & ~vs_prev_q;
            lfsr_q    <= lfsr_d;
            // Only ticks that land inside TRACK are ever evaluated.
            eval_q    <= tick_q && (state_q == S_TRACK);
            hit_r_q   <= 1'b0;
            hit_g_q   <= 1'b0;

            if (tick_q) begin
                xr_q <= lts.x_red;
                yr_q <= lts.y_red;
                xg_q <= lts.x_green;
                yg_q <= lts.y_green;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (lts.start) begin
                        score_r_q <= '0;
                        score_g_q <= '0;
                        rounds_q  <= 8'(NUM_ROUNDS);
                        state_q   <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    if (accept_d) begin
                        tx_q     <= 17'(cand_x_d) + 17'(TARGET_MARGIN);
                        ty_q     <= 17'(cand_y_d) + 17'(TARGET_MARGIN);
                        hold_r_q <= '0;
                        hold_g_q <= '0;
                        frame_q  <= '0;
                        active_q <= 1'b1;
                        state_q  <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (tick_q) begin
                        frame_q <= frame_q + FRAME_W'(1);
                    end
                    if (eval_q) begin
                        hold_r_q <= hold_r_d;
                        hold_g_q <= hold_g_d;
                        if (win_r_d || win_g_d) begin
                            hit_r_q  <= win_r_d;
                            hit_g_q  <= win_g_d;
                            active_q <= 1'b0;
                            state_q  <= S_SCORE;
                        end else if (32'(frame_q) >= ROUND_FRAMES) begin
                            active_q <= 1'b0;
                            state_q  <= S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (hit_r_q && (score_r_q != 8'hFF)) begin
                        score_r_q <= score_r_q + 8'd1;
                    end
                    if (hit_g_q && (score_g_q != 8'hFF)) begin
                        score_g_q <= score_g_q + 8'd1;
                    end
                    rounds_q <= rounds_dec_d;
                    state_q  <= (rounds_dec_d != '0) ? S_PLACE : S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lts.x_target     = 32'(tx_q);
    assign lts.y_target     = 32'(ty_q);
    assign lts.score_red    = score_r_q;
    assign lts.score_green  = score_g_q;
    assign lts.rounds_left  = rounds_q;
    assign lts.round_active = active_q;
    assign lts.hit_red      = hit_r_q;
    assign lts.hit_green    = hit_g_q;
    assign lts.state_dbg    = state_q;

endmodule

// File: tb/tb_laser_target_scheduler.sv
// Self-checking bench for laser_target_scheduler: frame-level scoring model
// plus an LFSR model used to predict each accepted target.
module tb_laser_target_scheduler;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk25 = 1'b0;
    logic reset = 1'b1;

    laser_target_scheduler_if bus();

    laser_target_scheduler #(
        .H_RES(320), .V_RES(240), .HIT_RADIUS(16), .HOLD_FRAMES(4),
        .ROUND_FRAMES(300), .NUM_ROUNDS(8), .TARGET_MARGIN(16), .LFSR_SEED(SEED)
    ) dut (
        .clk25(clk25),
        .reset(reset),
        .lts(bus)
    );

    always #20 clk25 = ~clk25;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_score_r = 0, m_score_g = 0, m_rounds = 0;
    int m_hold_r = 0, m_hold_g = 0, m_frames = 0;
    int m_tx = 160, m_ty = 120;

    logic [15:0] m_lfsr, m_lfsr_prev, m_acc;
    logic        m_ra_prev = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // The candidate accepted at the edge where round_active rises is the
    // LFSR value held during the cycle before that edge.
    always @(posedge clk25) begin
        m_lfsr_prev = m_lfsr;
        m_lfsr = reset ? SEED : lfsr_next(m_lfsr);
        #1;
        if (bus.round_active === 1'b1 && m_ra_prev !== 1'b1) m_acc = m_lfsr_prev;
        m_ra_prev = bus.round_active;
    end

    function automatic bit m_in_box(input int x, input int y, input int tx, input int ty);
        int dx, dy;
        dx = x - tx;
        dy = y - ty;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (x != 0 || y != 0) && dx <= 16 && dy <= 16;
    endfunction

    function automatic int rin(input int c);
        return c + int'($urandom_range(32)) - 16;
    endfunction

    task automatic model_frame(input int xr, input int yr, input int xg, input int yg,
                               output bit er, output bit eg);
        m_frames++;
        m_hold_r = m_in_box(xr, yr, m_tx, m_ty) ? m_hold_r + 1 : 0;
        m_hold_g = m_in_box(xg, yg, m_tx, m_ty) ? m_hold_g + 1 : 0;
        er = (m_hold_r == 4);
        eg = (m_hold_g == 4);
        if (er || eg || m_frames == 300) begin
            if (er && m_score_r < 255) m_score_r++;
            if (eg && m_score_g < 255) m_score_g++;
            if (m_rounds > 0) m_rounds--;
            m_hold_r = 0;
            m_hold_g = 0;
            m_frames = 0;
        end
    endtask

    task automatic model_reset();
        m_score_r = 0; m_score_g = 0; m_rounds = 0;
        m_hold_r = 0; m_hold_g = 0; m_frames = 0;
        m_tx = 160; m_ty = 120;
    endtask

    task automatic step_clk();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        m_score_r = 0;
        m_score_g = 0;
        m_rounds  = 8;
    endtask

    // One VSYNC pulse; reports the cycle (1-based, counted from the first edge
    // after the rise) and number of cycles each hit output was high.
    task automatic do_frame(input int xr, input int yr, input int xg, input int yg,
                            output int kr, output int kg, output int nr, output int ng);
        bus.x_red = 17'(xr); bus.y_red = 17'(yr);
        bus.x_green = 17'(xg); bus.y_green = 17'(yg);
        bus.vsync_raw = 1'b1;
        kr = 0; kg = 0; nr = 0; ng = 0;
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            if (k == 3) bus.vsync_raw = 1'b0;
            if (bus.hit_red === 1'b1) begin nr++; if (kr == 0) kr = k; end
            if (bus.hit_green === 1'b1) begin ng++; if (kg == 0) kg = k; end
        end
    endtask

    task automatic wait_track(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.round_active === 1'b1) begin ok = 1'b1; break; end
            step_clk();
        end
        #1;
        if (ok) begin
            m_tx = int'(m_acc[8:0]) + 16;
            m_ty = int'(m_acc[15:8]) + 16;
        end
    endtask

    task automatic test_reset();
        int pulses = 0;
        int bad_state = 0;
        reset = 1'b1;
        step_clk();
        step_clk();
        n_checks++; if (bus.x_target !== 32'd160) begin n_fail++; $display("FAIL reset_x_target: got %0d expected 160", bus.x_target); end
        n_checks++; if (bus.y_target !== 32'd120) begin n_fail++; $display("FAIL reset_y_target: got %0d expected 120", bus.y_target); end
        n_checks++; if (bus.score_red !== 8'd0 || bus.score_green !== 8'd0) begin n_fail++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", bus.score_red, bus.score_green); end
        n_checks++; if (bus.rounds_left !== 8'd0) begin n_fail++; $display("FAIL reset_rounds: got %0d expected 0", bus.rounds_left); end
        n_checks++; if (bus.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
        n_checks++; if (bus.round_active !== 1'b0 || bus.hit_red !== 1'b0 || bus.hit_green !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b expected 000", bus.round_active, bus.hit_red, bus.hit_green); end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step_clk();
            if (bus.hit_red === 1'b1 || bus.hit_green === 1'b1) pulses++;
            if (bus.state_dbg !== 3'd0) bad_state++;
        end
        n_checks++; if (pulses != 0 || bad_state != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d pulses %0d non-idle cycles expected 0", pulses, bad_state); end
    endtask

    task automatic check_target(input string tag);
        n_checks++;
        if (bus.x_target !== 32'(m_tx) || bus.y_target !== 32'(m_ty)) begin
            n_fail++; $display("FAIL %s_target: got (%0d,%0d) expected (%0d,%0d)", tag, bus.x_target, bus.y_target, m_tx, m_ty);
        end
        n_checks++;
        if (bus.x_target < 16 || bus.x_target > 303 || bus.y_target < 16 || bus.y_target > 223) begin
            n_fail++; $display("FAIL %s_target_range: got (%0d,%0d) expected within [16,303]x[16,223]", tag, bus.x_target, bus.y_target);
        end
    endtask

    task automatic test_single_hit();
        bit ok, er, eg;
        int kr, kg, nr, ng;
        do_start();
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_wait_track: got timeout expected TRACK"); end
        check_target("single_first");
        n_checks++; if (bus.rounds_left !== 8'd8 || bus.score_red !== 8'd0) begin n_fail++; $display("FAIL single_start_state: got rounds %0d score %0d expected 8/0", bus.rounds_left, bus.score_red); end
        for (int f = 1; f <= 4; f++) begin
            do_frame(m_tx + 16, m_ty - 16, 0, 0, kr, kg, nr, ng);
            model_frame(m_tx + 16, m_ty - 16, 0, 0, er, eg);
            n_checks++;
            if (kr != (er ? 5 : 0) || nr != (er ? 1 : 0) || ng != 0) begin
                n_fail++; $display("FAIL single_hit_f%0d: got red cycle %0d x%0d green x%0d expected red cycle %0d x%0d green x0", f, kr, nr, ng, er ? 5 : 0, er ? 1 : 0);
            end
        end
        n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL single_score: got score %0d rounds %0d expected %0d/%0d", bus.score_red, bus.rounds_left, m_score_r, m_rounds); end
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_wait_next: got timeout expected TRACK"); end
        check_target("single_next");
    endtask

    task automatic test_near_miss_and_dropout();
        bit ok, er, eg;
        int kr, kg, nr, ng, xr, yr;
        for (int f = 1; f <= 10; f++) begin
            do_frame(m_tx + 17, m_ty, 0, 0, kr, kg, nr, ng);
            model_frame(m_tx + 17, m_ty, 0, 0, er, eg);
            n_checks++; if (nr != 0 || er) begin n_fail++; $display("FAIL near_miss_f%0d: got %0d pulses expected 0", f, nr); end
        end
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        step_clk();
        n_checks++; if (bus.state_dbg !== 3'd2 || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL start_ignored: got state %0d rounds %0d expected 2/%0d", bus.state_dbg, bus.rounds_left, m_rounds); end
        for (int f = 1; f <= 8; f++) begin
            if (f == 4) begin xr = 0; yr = 0; end
            else begin xr = rin(m_tx); yr = rin(m_ty); end
            do_frame(xr, yr, 0, 0, kr, kg, nr, ng);
            model_frame(xr, yr, 0, 0, er, eg);
            n_checks++;
            if (kr != (er ? 5 : 0) || nr != (er ? 1 : 0) || er != (f == 8)) begin
                n_fail++; $display("FAIL dropout_f%0d: got red cycle %0d x%0d expected cycle %0d", f, kr, nr, (f == 8) ? 5 : 0);
            end
        end
        n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL dropout_score: got score %0d rounds %0d expected %0d/%0d", bus.score_red, bus.rounds_left, m_score_r, m_rounds); end
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dropout_wait_next: got timeout expected TRACK"); end
        check_target("dropout_next");
    endtask

    task automatic test_tie();
        bit ok, er, eg;
        int kr, kg, nr, ng, xr, yr, xg, yg;
        for (int f = 1; f <= 4; f++) begin
            xr = rin(m_tx); yr = rin(m_ty); xg = rin(m_tx); yg = rin(m_ty);
            do_frame(xr, yr, xg, yg, kr, kg, nr, ng);
            model_frame(xr, yr, xg, yg, er, eg);
            n_checks++;
            if (kr != (er ? 5 : 0) || kg != (eg ? 5 : 0) || nr != (er ? 1 : 0) || ng != (eg ? 1 : 0)) begin
                n_fail++; $display("FAIL tie_f%0d: got red %0d/x%0d green %0d/x%0d expected red %0d green %0d", f, kr, nr, kg, ng, er ? 5 : 0, eg ? 5 : 0);
            end
        end
        n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.score_green !== 8'(m_score_g)) begin n_fail++; $display("FAIL tie_scores: got %0d/%0d expected %0d/%0d", bus.score_red, bus.score_green, m_score_r, m_score_g); end
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tie_wait_next: got timeout expected TRACK"); end
        check_target("tie_next");
    endtask

    task automatic test_random_round();
        bit ok, er, eg;
        int kr, kg, nr, ng, xr, yr, xg, yg, start_rounds;
        start_rounds = m_rounds;
        for (int f = 1; f <= 300 && m_rounds == start_rounds; f++) begin
            if ($urandom_range(9) < 7) begin xr = rin(m_tx); yr = rin(m_ty); end
            else begin xr = int'($urandom_range(319)); yr = int'($urandom_range(239)); end
            if ($urandom_range(9) < 6) begin xg = rin(m_tx); yg = rin(m_ty); end
            else begin xg = 0; yg = 0; end
            do_frame(xr, yr, xg, yg, kr, kg, nr, ng);
            model_frame(xr, yr, xg, yg, er, eg);
            n_checks++;
            if (kr != (er ? 5 : 0) || kg != (eg ? 5 : 0) || nr != (er ? 1 : 0) || ng != (eg ? 1 : 0)) begin
                n_fail++; $display("FAIL random_f%0d: got red %0d/x%0d green %0d/x%0d expected red %0d green %0d", f, kr, nr, kg, ng, er ? 5 : 0, eg ? 5 : 0);
            end
        end
        n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.score_green !== 8'(m_score_g) || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL random_scores: got %0d/%0d rounds %0d expected %0d/%0d rounds %0d", bus.score_red, bus.score_green, bus.rounds_left, m_score_r, m_score_g, m_rounds); end
    endtask

    task automatic test_timeout_to_done();
        bit ok, er, eg;
        int kr, kg, nr, ng, pulses;
        while (m_rounds > 0) begin
            wait_track(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_wait_track: got timeout expected TRACK"); end
            check_target("timeout");
            pulses = 0;
            for (int f = 1; f <= 300; f++) begin
                do_frame(0, 0, 0, 0, kr, kg, nr, ng);
                model_frame(0, 0, 0, 0, er, eg);
                pulses += nr + ng;
                if (f == 299) begin
                    n_checks++; if (bus.round_active !== 1'b1) begin n_fail++; $display("FAIL timeout_f299_active: got %b expected 1", bus.round_active); end
                end
            end
            n_checks++; if (pulses != 0 || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL timeout_round: got %0d pulses rounds %0d expected 0 pulses rounds %0d", pulses, bus.rounds_left, m_rounds); end
            n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.score_green !== 8'(m_score_g)) begin n_fail++; $display("FAIL timeout_scores: got %0d/%0d expected %0d/%0d", bus.score_red, bus.score_green, m_score_r, m_score_g); end
        end
        repeat (20) step_clk();
        n_checks++; if (bus.state_dbg !== 3'd4 || bus.round_active !== 1'b0) begin n_fail++; $display("FAIL done_state: got state %0d active %b expected 4/0", bus.state_dbg, bus.round_active); end
        n_checks++; if (bus.x_target !== 32'(m_tx) || bus.y_target !== 32'(m_ty)) begin n_fail++; $display("FAIL done_target_held: got (%0d,%0d) expected (%0d,%0d)", bus.x_target, bus.y_target, m_tx, m_ty); end
        do_start();
        n_checks++; if (bus.score_red !== 8'd0 || bus.score_green !== 8'd0 || bus.rounds_left !== 8'd8) begin n_fail++; $display("FAIL done_restart: got %0d/%0d rounds %0d expected 0/0 rounds 8", bus.score_red, bus.score_green, bus.rounds_left); end
    endtask

    task automatic test_reset_mid_track();
        bit ok, er, eg;
        int kr, kg, nr, ng, xr, yr;
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_wait_track: got timeout expected TRACK"); end
        for (int f = 1; f <= 2; f++) begin
            xr = rin(m_tx); yr = rin(m_ty);
            do_frame(xr, yr, 0, 0, kr, kg, nr, ng);
            model_frame(xr, yr, 0, 0, er, eg);
        end
        reset = 1'b1;
        step_clk();
        n_checks++; if (bus.state_dbg !== 3'd0 || bus.round_active !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got state %0d active %b expected 0/0", bus.state_dbg, bus.round_active); end
        n_checks++; if (bus.x_target !== 32'd160 || bus.y_target !== 32'd120 || bus.rounds_left !== 8'd0 || bus.score_red !== 8'd0) begin n_fail++; $display("FAIL midreset_values: got (%0d,%0d) rounds %0d score %0d expected (160,120) 0 0", bus.x_target, bus.y_target, bus.rounds_left, bus.score_red); end
        reset = 1'b0;
        model_reset();
        do_start();
        wait_track(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_restart: got timeout expected TRACK"); end
        check_target("midreset");
        for (int f = 1; f <= 4; f++) begin
            xr = rin(m_tx); yr = rin(m_ty);
            do_frame(xr, yr, 0, 0, kr, kg, nr, ng);
            model_frame(xr, yr, 0, 0, er, eg);
            n_checks++;
            if (kr != (er ? 5 : 0) || nr != (er ? 1 : 0) || er != (f == 4)) begin
                n_fail++; $display("FAIL midreset_f%0d: got red cycle %0d x%0d expected cycle %0d", f, kr, nr, (f == 4) ? 5 : 0);
            end
        end
        n_checks++; if (bus.score_red !== 8'(m_score_r) || bus.rounds_left !== 8'(m_rounds)) begin n_fail++; $display("FAIL midreset_score: got %0d rounds %0d expected %0d/%0d", bus.score_red, bus.rounds_left, m_score_r, m_rounds); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.vsync_raw = 1'b0;
        bus.start     = 1'b0;
        bus.x_red     = '0;
        bus.y_red     = '0;
        bus.x_green   = '0;
        bus.y_green   = '0;
        test_reset();
        test_single_hit();
        test_near_miss_and_dropout();
        test_tie();
        test_random_round();
        test_timeout_to_done();
        test_reset_mid_track();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_target_scheduler.md
Name: laser_target_scheduler

Overview:
Game-round controller for the dual-laser datapath. It synchronises the camera VSYNC into the 25 MHz domain and places pseudo-random targets, driving x_target/y_target into the capture/overlay path. Each frame it compares the red and green laser centroids from the marker detectors against the current target, and keeps per-player scores over a fixed number of rounds. It sits beside the camera top level and owns the target coordinates.

Parameters:
H_RES, 320, active frame width in pixels
V_RES, 240, active frame height in pixels
HIT_RADIUS, 16, half-size of the square hit box around the target
HOLD_FRAMES, 4, consecutive in-box frames needed to win a round
ROUND_FRAMES, 300, frame ticks before a round times out
NUM_ROUNDS, 8, rounds per game
TARGET_MARGIN, 16, minimum target distance from any frame edge
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk25  in  1  system clock, 25 MHz
reset  in  1  synchronous, active-high reset
vsync_raw  in  1  OV7670 VSYNC, asynchronous to clk25
start  in  1  one-cycle pulse that starts a game
x_red, y_red  in  17 each  red centroid; (0,0) means no detection
x_green, y_green  in  17 each  green centroid; (0,0) means no detection
x_target, y_target  out  32 each  current target centre, zero-extended
score_red, score_green  out  8 each  per-player scores
rounds_left  out  8  rounds remaining in the game
round_active  out  1  high while in TRACK
hit_red, hit_green  out  1 each  one-cycle pulse when a player wins a round
state_dbg  out  3  encoded FSM state

Behaviour:
- Clock and reset: one clock, clk25. reset is synchronous and active-high. Reset mid-operation aborts the game immediately.
- Reset values:
  - state IDLE
  - x_target=H_RES/2 (160), y_target=V_RES/2 (120)
  - scores 0, rounds_left 0
  - round_active, hit_red, hit_green all 0
  - LFSR=LFSR_SEED, all counters 0
- VSYNC handling:
  - two-flop synchroniser, then rising-edge detect.
  - frame_tick is a one-cycle pulse 3 clk25 cycles after the VSYNC rise.
- Coordinate sampling:
  - all four coordinates are registered on the frame_tick cycle (T).
  - comparison uses only these registered copies.
- Hit test, evaluated at T+1:
  - in_box = |x - x_target| <= HIT_RADIUS AND |y - y_target| <= HIT_RADIUS AND NOT (x==0 AND y==0).
  - differences are computed as 18-bit signed, then absolute value.
- Hold counters, one per player (width fits HOLD_FRAMES), updated at T+1 in TRACK only:
  - in_box: increment.
  - otherwise: clear to 0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - advances every cycle in every state, so targets depend on when start arrives.
- States:
  - IDLE: start -> scores=0, rounds_left=NUM_ROUNDS, go PLACE.
  - PLACE:
    - candidate cx=lfsr[8:0], cy=lfsr[15:8].
    - accept only if cx < H_RES-2*TARGET_MARGIN AND cy < V_RES-2*TARGET_MARGIN.
    - on accept: x_target=cx+TARGET_MARGIN, y_target=cy+TARGET_MARGIN; clear hold counters and frame counter; go TRACK.
    - otherwise retry next cycle.
  - TRACK:
    - round_active=1; frame counter increments on each frame_tick.
    - any hold counter reaching HOLD_FRAMES at T+1 -> SCORE at T+2.
    - else frame counter reaching ROUND_FRAMES -> SCORE with no winner.
  - SCORE, one cycle:
    - hit_x pulses for each winner; both players can win on the same tick (tie: both score).
    - scores update and rounds_left decrements (saturating at 0), both visible at T+3.
    - go PLACE if the decremented rounds_left is nonzero, else DONE.
  - DONE: scores and target held, round_active=0. start -> same action as in IDLE.
- start is ignored in PLACE, TRACK and SCORE.
- Scores saturate at 255.
- A frame_tick arriving during PLACE or SCORE is discarded. The next round counts only ticks after it enters TRACK.
- state_dbg encoding: IDLE=0, PLACE=1, TRACK=2, SCORE=3, DONE=4.

Test Plan:
1. Reset for 2 cycles -> x_target=160, y_target=120, scores 0, rounds_left 0, state_dbg=0; no pulses for 100 cycles without start.
2. start; once in TRACK with target (tx,ty), drive red=(tx+16,ty-16) for 4 vsync pulses -> hit_red pulses exactly 5 clk25 cycles after the 4th VSYNC rise. Then score_red=1, rounds_left=7, and the new target lies in [16,303]x[16,223].
3. Red at (tx+17,ty) for 10 frames -> no hit. Red inside for 3 frames, (0,0) for 1 frame, inside for 4 frames -> a single hit, on the 8th frame.
4. Red and green both inside for 4 frames -> hit_red and hit_green pulse on the same cycle; both scores become 1.
5. Lasers absent for 300 frames -> SCORE with no pulses, scores unchanged, rounds_left decrements. After 8 such rounds -> DONE, round_active=0; start -> scores 0, rounds_left=8.
6. Assert reset mid-TRACK after 2 in-box frames -> IDLE and all reset values on the next cycle; start then requires a full 4 new frames for a hit.
